// File: rtl/usbt_parse_pkg.sv
// rtl/usbt_parse_pkg.sv - shared entry layout and sizing helpers for the parse output buffer
package usbt_parse_pkg;

    // Entry layout, LSB first: data, endp, entry_type, d_width[1:0], error, eop
    localparam int D_WIDTH_W = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int entry_width(input int cod_endp_width, input int data_width);
        return 5 + cod_endp_width + data_width;
    endfunction

    function automatic int off_data(input int cod_endp_width, input int data_width);
        return 0 * (cod_endp_width + data_width);
    endfunction

    function automatic int off_endp(input int cod_endp_width, input int data_width);
        return data_width + 0 * cod_endp_width;
    endfunction

    function automatic int off_entry_type(input int cod_endp_width, input int data_width);
        return data_width + cod_endp_width;
    endfunction

    function automatic int off_d_width(input int cod_endp_width, input int data_width);
        return data_width + cod_endp_width + 1;
    endfunction

    function automatic int off_err(input int cod_endp_width, input int data_width);
        return data_width + cod_endp_width + 1 + D_WIDTH_W;
    endfunction

    function automatic int off_eop(input int cod_endp_width, input int data_width);
        return data_width + cod_endp_width + 2 + D_WIDTH_W;
    endfunction

endpackage

// File: rtl/usbt_parse_chan_fifo.sv
// rtl/usbt_parse_chan_fifo.sv - one channel FIFO with hysteresis, packet drop and statistics
module usbt_parse_chan_fifo
    import usbt_parse_pkg::*;
#(
    parameter int AWIDTH         = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int COD_ENDP_WIDTH = 6,
    parameter int CNT_WIDTH      = 8,
    localparam int ENTRY_WIDTH   = entry_width(COD_ENDP_WIDTH, DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [ENTRY_WIDTH-1:0] push_data,
    input  logic                   pop,
    input  logic [AWIDTH:0]        start_wr_again_th,
    input  logic                   max_used_clr,
    input  logic                   overflow_clr,
    input  logic                   cnt_clr,
    output logic                   wr_ready,
    output logic                   empty,
    output logic [ENTRY_WIDTH-1:0] head,
    output logic [AWIDTH:0]        used,
    output logic [AWIDTH:0]        max_used,
    output logic                   overflow,
    output logic [CNT_WIDTH-1:0]   pkt_cnt,
    output logic [CNT_WIDTH-1:0]   drop_cnt
);

    localparam int EOP_BIT = off_eop(COD_ENDP_WIDTH, DATA_WIDTH);
    localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] UONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] PONE = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [ENTRY_WIDTH-1:0] mem_q [2**AWIDTH];
    logic [AWIDTH-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AWIDTH:0]        used_q, used_d, max_q, max_d;
    logic                   ready_q, ready_d, drop_q, drop_d, ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]   pkt_q, pkt_d, drp_q, drp_d;
    logic                   accept, discard;

    // Once a packet has lost an entry, the rest of it is discarded even if space reopens
    assign accept  = push && ready_q && !drop_q;
    assign discard = push && !accept;

    // Next-state for fill level, hysteresis, drop tracking and statistics
    always_comb begin
        wptr_d  = accept ? wptr_q + PONE : wptr_q;
        rptr_d  = pop ? rptr_q + PONE : rptr_q;
        used_d  = used_q;
        if (accept && !pop) begin
            used_d = used_q + UONE;
        end else if (!accept && pop) begin
            used_d = used_q - UONE;
        end
        ready_d = ready_q;
        if (used_d == DEPTH) begin
            ready_d = 1'b0;
        end else if (used_q <= start_wr_again_th && used_q != DEPTH) begin
            ready_d = 1'b1;
        end
        drop_d = discard ? !push_data[EOP_BIT] : drop_q;
        ovf_d  = discard ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
        max_d  = max_used_clr ? used_q : ((used_q > max_q) ? used_q : max_q);
        pkt_d  = pkt_q;
        if (cnt_clr) begin
            pkt_d = '0;
        end else if (accept && push_data[EOP_BIT]) begin
            pkt_d = pkt_q + CONE;
        end
        drp_d = drp_q;
        if (cnt_clr) begin
            drp_d = '0;
        end else if (discard && drp_q != '1) begin
            drp_d = drp_q + CONE;
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            used_q  <= '0;
            max_q   <= '0;
            ready_q <= 1'b1;
            drop_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pkt_q   <= '0;
            drp_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            used_q  <= used_d;
            max_q   <= max_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            pkt_q   <= pkt_d;
            drp_q   <= drp_d;
        end
    end

    // Entry storage; contents are meaningless while the pointers say empty
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    assign wr_ready = ready_q;
    assign empty    = (used_q == '0);
    assign head     = mem_q[rptr_q];
    assign used     = used_q;
    assign max_used = max_q;
    assign overflow = ovf_q;
    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drp_q;

endmodule

// File: rtl/usbt_parse_out_buffer.sv
// rtl/usbt_parse_out_buffer.sv - multi-channel parsed-entry buffer with packet-atomic round-robin output
module usbt_parse_out_buffer
    import usbt_parse_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int AWIDTH         = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int COD_ENDP_WIDTH = 6,
    parameter int CNT_WIDTH      = 8,
    localparam int ENTRY_WIDTH   = entry_width(COD_ENDP_WIDTH, DATA_WIDTH),
    localparam int CH_W          = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_cmd,
    input  logic [CH_W-1:0]               wr_ch,
    input  logic [ENTRY_WIDTH-1:0]        wr_data,
    output logic [NUM_CH-1:0]             wr_ready,
    input  logic [AWIDTH:0]               start_wr_again_th,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [ENTRY_WIDTH-1:0]        rd_data,
    output logic [CH_W-1:0]               rd_ch,
    output logic [NUM_CH*(AWIDTH+1)-1:0]  used,
    output logic [NUM_CH*(AWIDTH+1)-1:0]  max_used,
    input  logic [NUM_CH-1:0]             max_used_clr,
    output logic [NUM_CH-1:0]             overflow,
    input  logic [NUM_CH-1:0]             overflow_clr,
    output logic [NUM_CH*CNT_WIDTH-1:0]   pkt_cnt,
    output logic [NUM_CH*CNT_WIDTH-1:0]   drop_cnt,
    input  logic                          cnt_clr
);

    localparam int EOP_BIT = off_eop(COD_ENDP_WIDTH, DATA_WIDTH);

    logic [NUM_CH-1:0]      fifo_empty, pop_vec;
    logic [ENTRY_WIDTH-1:0] head [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        usbt_parse_chan_fifo #(
            .AWIDTH(AWIDTH), .DATA_WIDTH(DATA_WIDTH),
            .COD_ENDP_WIDTH(COD_ENDP_WIDTH), .CNT_WIDTH(CNT_WIDTH)
        ) u_fifo (
            .clk(clk), .reset_n(reset_n),
            .push(wr_cmd && (wr_ch == CH_W'(c))), .push_data(wr_data),
            .pop(pop_vec[c]), .start_wr_again_th(start_wr_again_th),
            .max_used_clr(max_used_clr[c]), .overflow_clr(overflow_clr[c]), .cnt_clr(cnt_clr),
            .wr_ready(wr_ready[c]), .empty(fifo_empty[c]), .head(head[c]),
            .used(used[c*(AWIDTH+1) +: AWIDTH+1]), .max_used(max_used[c*(AWIDTH+1) +: AWIDTH+1]),
            .overflow(overflow[c]),
            .pkt_cnt(pkt_cnt[c*CNT_WIDTH +: CNT_WIDTH]), .drop_cnt(drop_cnt[c*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    logic                   lock_q, lock_d;
    logic [CH_W-1:0]        gnt_q, gnt_d, rr_q, rr_d, sel, cand;
    logic                   avail, load;
    logic                   rd_valid_q, rd_valid_d;
    logic [ENTRY_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [CH_W-1:0]        rd_ch_q, rd_ch_d;
    int                     k;

    // Arbitration and output-register load: a locked channel is served exclusively until its eop leaves
    always_comb begin
        sel        = gnt_q;
        cand       = '0;
        avail      = 1'b0;
        k          = 0;
        lock_d     = lock_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_ch_d    = rd_ch_q;
        if (lock_q) begin
            avail = !fifo_empty[gnt_q];
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                k = int'(rr_q) + i;
                if (k >= NUM_CH) begin
                    k = k - NUM_CH;
                end
                cand = k[CH_W-1:0];
                if (!avail && !fifo_empty[cand]) begin
                    avail = 1'b1;
                    sel   = cand;
                end
            end
        end
        load    = !rd_valid_q || rd_ready;
        pop_vec = '0;
        pop_vec[sel] = load && avail;
        if (load) begin
            rd_valid_d = avail;
            if (avail) begin
                rd_data_d = head[sel];
                rd_ch_d   = sel;
                if (head[sel][EOP_BIT]) begin
                    lock_d = 1'b0;
                    rr_d   = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
                end else begin
                    lock_d = 1'b1;
                    gnt_d  = sel;
                end
            end
        end
    end

    // Arbiter state and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q     <= 1'b0;
            gnt_q      <= '0;
            rr_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
        end else begin
            lock_q     <= lock_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ch_q    <= rd_ch_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_ch    = rd_ch_q;

endmodule

// File: doc/usbt_parse_out_buffer.md
Name: usbt_parse_out_buffer

Overview:
- Multi-channel successor to the single parsed-entry output FIFO of the USB main-parse path.
- Holds NUM_CH independent FIFOs of parsed entries {eop, error, d_width, entry_type, endp_entry, data} behind one write port tagged by channel.
- A packet-atomic round-robin read arbiter feeds one registered valid/ready output stream toward the CPU/DMA side.
- Adds per-channel full hysteresis, overflow packet-drop, high-water marks and packet counters.

Parameters:
- NUM_CH, 4, number of channels (1..16).
- AWIDTH, 4, log2 of per-channel depth (depth = 2^AWIDTH).
- DATA_WIDTH, 32, data field width.
- COD_ENDP_WIDTH, 6, coded endpoint field width.
- CNT_WIDTH, 8, packet/drop counter width.
- ENTRY_WIDTH (local), 5+COD_ENDP_WIDTH+DATA_WIDTH; bit ENTRY_WIDTH-1 is eop.
- CH_W (local), max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  block clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_cmd  in  1  write strobe.
- wr_ch  in  CH_W  target channel.
- wr_data  in  ENTRY_WIDTH  entry; MSB is eop.
- wr_ready  out  NUM_CH  per-channel accept indication.
- start_wr_again_th  in  AWIDTH+1  hysteresis re-open level.
- rd_valid  out  1  output entry valid.
- rd_ready  in  1  consumer accept.
- rd_data  out  ENTRY_WIDTH  output entry.
- rd_ch  out  CH_W  channel of rd_data.
- used  out  NUM_CH*(AWIDTH+1)  per-channel fill level.
- max_used  out  NUM_CH*(AWIDTH+1)  per-channel high-water mark.
- max_used_clr  in  NUM_CH  per-channel clear pulse.
- overflow  out  NUM_CH  sticky drop flag.
- overflow_clr  in  NUM_CH  per-channel clear pulse.
- pkt_cnt  out  NUM_CH*CNT_WIDTH  accepted eop entries, wraps.
- drop_cnt  out  NUM_CH*CNT_WIDTH  dropped entries, saturates.
- cnt_clr  in  1  clears pkt_cnt and drop_cnt.

Behaviour:
- Reset: all outputs 0 except wr_ready = all ones. Arbiter unlocked; rr pointer = 0; all FIFOs empty; drop state cleared.
- Accept rule: an entry is accepted when wr_cmd=1 and wr_ready[wr_ch]=1 and chan not in drop state. used[wr_ch] increments at the next edge.
- wr_ready[c]:
  - Clears at the edge where used[c] becomes 2^AWIDTH.
  - Re-sets at the edge after used[c] <= start_wr_again_th.
  - start_wr_again_th >= 2^AWIDTH means no hysteresis.
- Drop state:
  - wr_cmd to a channel with wr_ready=0 discards the entry; overflow[c] is set; drop_cnt[c] increments.
  - If that entry's eop=0, the channel enters drop state. All further entries to it, including the eop entry, are discarded and counted.
  - Drop state exits after the discarded eop entry.
  - An eop entry dropped while the channel is not in drop state does not enter drop state.
- pkt_cnt[c] increments on each accepted eop entry.
- Simultaneous push and pop on the same channel: used unchanged; both take effect.
- Read arbiter:
  - When unlocked, grant the first non-empty channel searching from rr pointer upward, with wrap.
  - Lock the granted channel until its eop entry is popped.
  - After that, rr = granted+1 mod NUM_CH, then unlock.
  - While locked, if the locked channel is empty, no other channel is served (packet atomicity).
- Output register:
  - Loads when !rd_valid || rd_ready.
  - rd_data/rd_ch hold stable while rd_valid && !rd_ready.
  - Minimum latency: entry accepted at edge N → rd_valid high after edge N+1.
  - Sustained 1 entry/cycle when rd_ready stays high.
- max_used[c] = max of used[c] sampled each cycle. If max_used_clr[c] is asserted, it loads the current used[c] instead (the clear wins).
- overflow_clr coincident with a new drop: the flag stays set.
- cnt_clr coincident with an increment: the counter loads 0 (the clear wins).
- drop_cnt saturates at all ones. pkt_cnt wraps.
- Async reset mid-packet discards all contents and releases the arbiter lock.

Decomposition:
- Shared package usbt_parse_pkg holds:
  - entry field offsets (EOP, ERR, D_WIDTH, ENTRY_TYPE, ENDP, DATA) as functions of COD_ENDP_WIDTH/DATA_WIDTH;
  - the clog2 function;
  - the ENTRY_WIDTH formula.
- Sub-module usbt_parse_chan_fifo, instantiated NUM_CH times, contains:
  - register-array FIFO;
  - used counter;
  - wr_ready hysteresis;
  - drop state;
  - max_used, overflow and counters.
- The top level holds the arbiter and the output register.

Test Plan:
- Single packet, 3 entries on ch2 (eop on the third), rd_ready=1 → rd_valid from cycle 2 for 3 consecutive cycles; rd_ch=2; pkt_cnt[2]=1; used[2] returns to 0.
- AWIDTH=4, 17 entries to ch0 with eop on entry 17, no reads, th=8 → first 16 accepted; entry 17 dropped; overflow[0]=1; drop_cnt[0]=1; pkt_cnt[0]=0; wr_ready[0] low until used[0]=8.
- Full ch1 mid-packet (eop=0 drop), then 4 more entries ending with eop, reads draining meanwhile → all 5 discarded; drop_cnt[1]=5; next packet accepted normally.
- ch0 and ch3 each hold a 4-entry packet, ch0 packet still incomplete (2 entries) → output shows ch0 entries, stalls; ch3 not served until ch0 eop arrives; then ch3; rr=1.
- rd_ready held low 5 cycles with rd_valid=1 → rd_data/rd_ch constant; no entry lost or duplicated.
- max_used_clr[0] pulsed while used[0]=6 and a push occurs the same cycle → max_used[0]=6 next cycle, 7 the cycle after.
